// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types, constants and bypass-match helper for the ARK register file
package ark_rf_pkg;

    // Number of write ports
    localparam int NWP = 2;

    // Widest address the match helper accepts; callers zero-extend into it
    localparam int MAX_D = 16;

    // Default datapath geometry
    localparam int DEF_W = 32;
    localparam int DEF_D = 5;

    typedef logic [DEF_D-1:0] addr_t;
    typedef logic [DEF_W-1:0] word_t;
    typedef logic [MAX_D-1:0] addr_ext_t;

    // True when an enabled write port targets the read address; register 0
    // never forwards when it is hard-wired to zero
    function automatic logic rf_match(input logic en, input addr_ext_t waddr,
                                      input addr_ext_t raddr, input logic zero_en);
        return en && (waddr == raddr) && !(zero_en && (raddr == '0));
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - decode/writeback bus for the multi-port register file
interface reg_file_mp_if
    import ark_rf_pkg::*;
#(
    parameter int W  = 32,
    parameter int D  = 5,
    parameter int NR = 3
);
    logic [NWP-1:0]         RegWrite;
    logic [NWP-1:0][D-1:0]  writeReg;
    logic [NWP-1:0][W-1:0]  writeValue;
    logic [NR-1:0][D-1:0]   srcReg;
    logic [NR-1:0][W-1:0]   ReadData;
    logic [NR-1:0]          ReadBusy;
    logic                   MarkBusy;
    logic [D-1:0]           markReg;

    modport master (
        output RegWrite, writeReg, writeValue, srcReg, MarkBusy, markReg,
        input  ReadData, ReadBusy
    );

    modport slave (
        input  RegWrite, writeReg, writeValue, srcReg, MarkBusy, markReg,
        output ReadData, ReadBusy
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// rtl/reg_file_mp_scoreboard.sv - per-register busy bits tracking outstanding writebacks
module rf_scoreboard
    import ark_rf_pkg::*;
#(
    parameter int D        = 5,
    parameter int NR       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NWP-1:0]         clr_en,
    input  logic [NWP-1:0][D-1:0]  clr_addr,
    input  logic                   mark,
    input  logic [D-1:0]           mark_addr,
    input  logic [NR-1:0][D-1:0]   rd_addr,
    output logic [NR-1:0]          rd_busy
);
    localparam int   DEPTH   = 1 << D;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Writebacks retire their register first, then a new mark re-arms it so
    // a fresh producer supersedes the one completing on the same edge
    always_comb begin
        busy_next = busy;
        for (int p = 0; p < NWP; p++) begin
            if (clr_en[p]) begin
                busy_next[clr_addr[p]] = 1'b0;
            end
        end
        if (mark && !(ZERO_EN && (mark_addr == '0))) begin
            busy_next[mark_addr] = 1'b1;
        end
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Lookups report registered state only; held low while in reset
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            rd_busy[i] = resetn & busy[rd_addr[i]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - NR-read / 2-write register file with bypass, zero register and busy scoreboard
module reg_file_mp
    import ark_rf_pkg::*;
#(
    parameter int W        = 32,
    parameter int D        = 5,
    parameter int NR       = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    reg_file_mp_if.slave  bus
);
    localparam int   DEPTH   = 1 << D;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [W-1:0] regs [DEPTH];

    // Storage: ports applied in index order so port 1 wins a collision
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (bus.RegWrite[p] && !(ZERO_EN && (bus.writeReg[p] == '0))) begin
                    regs[bus.writeReg[p]] <= bus.writeValue[p];
                end
            end
        end
    end

    // Read mux: array, then same-cycle forwarding (port 1 last), then zero override
    always_comb begin
        bus.ReadData = '0;
        for (int i = 0; i < NR; i++) begin
            bus.ReadData[i] = regs[bus.srcReg[i]];
            if (BYP_EN && RSTn) begin
                for (int p = 0; p < NWP; p++) begin
                    if (rf_match(bus.RegWrite[p], addr_ext_t'(bus.writeReg[p]),
                                 addr_ext_t'(bus.srcReg[i]), ZERO_EN)) begin
                        bus.ReadData[i] = bus.writeValue[p];
                    end
                end
            end
            if (ZERO_EN && (bus.srcReg[i] == '0)) begin
                bus.ReadData[i] = '0;
            end
        end
    end

    rf_scoreboard #(
        .D        (D),
        .NR       (NR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (CLK),
        .resetn    (RSTn),
        .clr_en    (bus.RegWrite),
        .clr_addr  (bus.writeReg),
        .mark      (bus.MarkBusy),
        .mark_addr (bus.markReg),
        .rd_addr   (bus.srcReg),
        .rd_busy   (bus.ReadBusy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp against a behavioural register-file model
module tb_reg_file_mp;
    import ark_rf_pkg::*;

    localparam int W     = 32;
    localparam int D     = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 1 << D;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    always #5 CLK = ~CLK;

    reg_file_mp_if #(.W(W), .D(D), .NR(NR)) bus ();

    reg_file_mp #(
        .W(W), .D(D), .NR(NR), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NR-1:0][W-1:0] data;
        logic [NR-1:0]        busy;
    } exp_t;

    exp_t  exp_q[$];
    string lbl_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    word_t mem    [DEPTH];
    bit    busy_m [DEPTH];

    // Expected read view: registered contents, newest write forwarded, r0 = 0
    function automatic exp_t model_expect();
        exp_t e;
        e = '0;
        for (int i = 0; i < NR; i++) begin
            int    a;
            word_t v;
            a = int'(bus.srcReg[i]);
            v = mem[a];
            if (RSTn) begin
                for (int p = 0; p < 2; p++) begin
                    if (bus.RegWrite[p] && int'(bus.writeReg[p]) == a) v = bus.writeValue[p];
                end
            end
            if (a == 0) v = '0;
            e.data[i] = v;
            e.busy[i] = RSTn ? busy_m[a] : 1'b0;
        end
        return e;
    endfunction

    // Architectural effect of one clock edge
    task automatic model_edge();
        if (!RSTn) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r]    = '0;
                busy_m[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.RegWrite[p]) begin
                    busy_m[int'(bus.writeReg[p])] = 1'b0;
                    if (bus.writeReg[p] != '0) mem[int'(bus.writeReg[p])] = bus.writeValue[p];
                end
            end
            if (bus.MarkBusy && bus.markReg != '0) busy_m[int'(bus.markReg)] = 1'b1;
        end
    endtask

    task automatic set_in(input logic [1:0] rw,
                          input int wr0, input word_t wv0,
                          input int wr1, input word_t wv1,
                          input int s0, input int s1, input int s2,
                          input logic mk, input int mr);
        bus.RegWrite      = rw;
        bus.writeReg[0]   = D'(wr0);
        bus.writeValue[0] = wv0;
        bus.writeReg[1]   = D'(wr1);
        bus.writeValue[1] = wv1;
        bus.srcReg[0]     = D'(s0);
        bus.srcReg[1]     = D'(s1);
        bus.srcReg[2]     = D'(s2);
        bus.MarkBusy      = mk;
        bus.markReg       = D'(mr);
    endtask

    // Publish the expected view for this cycle, then advance one edge
    task automatic step(input bit chk, input string lbl);
        if (chk) begin
            exp_q.push_back(model_expect());
            lbl_q.push_back(lbl);
        end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Monitor: compare every published expectation at the falling edge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            for (int i = 0; i < NR; i++) begin
                n_checks++;
                if (bus.ReadData[i] === e.data[i]) n_pass++;
                else $display("FAIL %s data[%0d] got %h expected %h", l, i, bus.ReadData[i], e.data[i]);
                n_checks++;
                if (bus.ReadBusy[i] === e.busy[i]) n_pass++;
                else $display("FAIL %s busy[%0d] got %b expected %b", l, i, bus.ReadBusy[i], e.busy[i]);
            end
        end
    end

    initial begin
        set_in(2'b00, 0, '0, 0, '0, 0, 0, 0, 1'b0, 0);
        RSTn = 1'b0;
        step(1'b0, "init");
        RSTn = 1'b1;

        // Preload 1..3 and leave reg 6 busy
        set_in(2'b11, 1, 32'h0000_1111, 2, 32'h0000_2222, 1, 2, 3, 1'b0, 0);
        step(1'b1, "preload_a");
        set_in(2'b01, 3, 32'h0000_3333, 0, '0, 1, 2, 6, 1'b1, 6);
        step(1'b1, "preload_b");

        // Reset cycle with a write that must be ignored
        RSTn = 1'b0;
        set_in(2'b01, 5, 32'h5555_5555, 0, '0, 1, 2, 3, 1'b1, 6);
        step(1'b1, "reset_cycle");
        RSTn = 1'b1;
        set_in(2'b00, 0, '0, 0, '0, 1, 2, 5, 1'b0, 0);
        step(1'b1, "after_reset_a");
        set_in(2'b00, 0, '0, 0, '0, 3, 6, 5, 1'b0, 0);
        step(1'b1, "after_reset_b");

        // Basic write and read
        set_in(2'b01, 1, 32'h6789_ABCD, 0, '0, 1, 0, 2, 1'b0, 0);
        step(1'b1, "wr_bypass");
        set_in(2'b00, 0, '0, 0, '0, 1, 1, 0, 1'b0, 0);
        step(1'b1, "wr_read");

        // Zero register on both ports
        set_in(2'b11, 0, 32'hFEDC_2030, 0, 32'hFEDC_2030, 1, 0, 0, 1'b0, 0);
        step(1'b1, "zero_bypass");
        set_in(2'b00, 0, '0, 0, '0, 0, 0, 1, 1'b0, 0);
        step(1'b1, "zero_read");

        // Same-address collision
        set_in(2'b11, 7, 32'h1111_1111, 7, 32'h2222_2222, 7, 7, 1, 1'b0, 0);
        step(1'b1, "coll_bypass");
        set_in(2'b00, 0, '0, 0, '0, 7, 1, 7, 1'b0, 0);
        step(1'b1, "coll_read");

        // Write disabled
        set_in(2'b00, 2, 32'h0000_ABCD, 2, 32'h0000_ABCD, 2, 2, 2, 1'b0, 0);
        step(1'b1, "wr_disabled");
        set_in(2'b00, 0, '0, 0, '0, 2, 0, 0, 1'b0, 0);
        step(1'b1, "dis_read");

        // Scoreboard mark / set-wins / clear
        set_in(2'b00, 0, '0, 0, '0, 4, 0, 0, 1'b1, 4);
        step(1'b1, "mark4");
        set_in(2'b10, 0, '0, 4, 32'h4444_0000, 4, 0, 0, 1'b1, 4);
        step(1'b1, "write_mark4");
        set_in(2'b01, 4, 32'h4444_0001, 0, '0, 4, 4, 0, 1'b0, 0);
        step(1'b1, "write_clear4");
        set_in(2'b00, 0, '0, 0, '0, 4, 0, 4, 1'b0, 0);
        step(1'b1, "busy4_cleared");
        set_in(2'b00, 0, '0, 0, '0, 0, 0, 0, 1'b1, 0);
        step(1'b1, "mark_r0");
        set_in(2'b00, 0, '0, 0, '0, 0, 4, 0, 1'b0, 0);
        step(1'b1, "r0_not_busy");

        // Randomized traffic over a small address window to force hits
        for (int n = 0; n < 400; n++) begin
            RSTn = ($urandom_range(0, 59) != 0);
            set_in(2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), word_t'($urandom()),
                   int'($urandom_range(0, 7)), word_t'($urandom()),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            step(1'b1, "random");
        end
        RSTn = 1'b1;
        set_in(2'b00, 0, '0, 0, '0, 0, 0, 0, 1'b0, 0);
        step(1'b0, "idle");
        repeat (3) @(posedge CLK);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Multi-port register file for the ARK datapath. Generalises the two-read/one-write file to NR read ports and two write ports, with optional write-to-read bypass. Register 0 is hard-wired to zero. A per-register busy scoreboard tracks outstanding writebacks so the issue stage can detect RAW hazards. Sits between decode (read/mark) and writeback (write/clear).

Parameters:
W, 32, data width in bits
D, 5, address width; depth = 2**D registers
NR, 3, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, and is never busy

Ports:
CLK  in  1  clock; all state updates on rising edge
RSTn  in  1  synchronous reset, active low
RegWrite  in  2  write enable, one bit per write port
writeReg  in  2 x D  write addresses, index 0 and 1
writeValue  in  2 x W  write data
srcReg  in  NR x D  read addresses
ReadData  out  NR x W  read data, combinational
ReadBusy  out  NR  1 = addressed register has a pending producer
MarkBusy  in  1  issue stage: set busy bit for markReg
markReg  in  D  register to mark busy

Behaviour:
- Reset: on a rising edge with RSTn=0, all 2**D registers and all busy bits clear to 0. Writes and marks in that cycle are ignored. While RSTn=0, bypass is disabled, so ReadData shows array contents (0 after the first reset edge) and ReadBusy=0.
- Write: on a rising edge with RSTn=1, port p with RegWrite[p]=1 writes writeValue[p] to writeReg[p]. Writes take effect at the edge; the array is visible to reads from the next cycle.
- Write collision: both ports enabled to the same address -> port 1 wins; port 0 data is discarded.
- Zero register (ZERO_REG=1): writes to address 0 are dropped. ReadData for srcReg=0 is always 0, including under bypass. MarkBusy on reg 0 is ignored.
- Read: ReadData[i] = array[srcReg[i]], combinational, zero latency.
- Bypass (BYPASS=1, RSTn=1): if RegWrite[p]=1 and writeReg[p]==srcReg[i] (and address is not 0 when ZERO_REG=1), ReadData[i]=writeValue[p]. When both ports match, port 1 takes priority, consistent with collision rule.
- Scoreboard:
  - busy[r] is set on an edge when MarkBusy=1 and markReg=r.
  - busy[r] is cleared on an edge when any enabled write port targets r.
  - Same-edge set and clear of the same r: set wins (new producer supersedes the old one).
- ReadBusy[i] = busy[srcReg[i]], registered state only (no bypass). A register being written this cycle with no re-mark still reports busy until the edge. With BYPASS=1 the data is already valid; the consumer resolves this by comparing against write addresses.
- No X propagation: all state is 2-state after the first reset edge.

Decomposition:
- Package ark_rf_pkg: localparam NWP=2; typedefs for the address type (logic [D-1:0]) and the data word; function rf_match(en, waddr, raddr, zero_en) returning the bypass hit.
- Sub-module rf_scoreboard (busy-bit vector, mark/clear/priority logic, NR lookup ports) is natural and is verified standalone.
- Array storage and bypass mux stay in the top level.

Test Plan:
- Reset: preload regs 1..3 with nonzero values, assert RSTn=0 for one edge -> all ReadData=0 and ReadBusy=0; a RegWrite=2'b01 to reg 5 asserted in the same cycle is not stored.
- Basic write/read: write 32'h6789ABCD to reg 1 via port 0, then on the next cycle srcReg[0]=1 -> ReadData[0]=32'h6789ABCD; with BYPASS=1, ReadData[0] also shows 32'h6789ABCD in the write cycle itself.
- Zero register: write 32'hFEDC2030 to reg 0 on both ports with srcReg[1]=0 -> ReadData[1]=0 in the write cycle and in the next cycle.
- Collision: port 0 writes 32'h11111111 and port 1 writes 32'h22222222 to reg 7 -> bypassed read is 32'h22222222, and the stored value read the next cycle is 32'h22222222.
- Write disabled: RegWrite=2'b00, writeReg=2, writeValue=32'hABCD -> reg 2 keeps its prior value 0.
- Scoreboard: MarkBusy on reg 4 -> next cycle ReadBusy=1 for srcReg=4. A port 1 write to reg 4 plus MarkBusy on reg 4 in the same cycle -> busy stays 1. A later write with no mark -> busy=0 the following cycle.
